// File: rtl/handshake_resync_tx.sv
// handshake_resync_tx: send-domain side of the valid/ack/data CDC resync.
// Takes one word at a time from a valid/ready stream and runs a four-phase
// req/ack handshake, holding o_hs_data stable for the full exchange.
// i_hs_ack is expected to be the already-synchronised acknowledge.
// Optional: define HANDSHAKE_TX_TIMEOUT_EN to abort a request that is not
// acknowledged within TIMEOUT_CYCLES cycles (sticky o_timeout flag).
module handshake_resync_tx #(
  parameter int DATA_WIDTH     = 8,
  parameter int COUNT_WIDTH    = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_s_valid,
  output logic                   o_s_ready,
  input  logic [DATA_WIDTH-1:0]  i_s_data,
  output logic                   o_hs_valid,
  input  logic                   i_hs_ack,
  output logic [DATA_WIDTH-1:0]  o_hs_data,
  output logic                   o_busy,
  output logic [COUNT_WIDTH-1:0] o_xfer_count,
  output logic                   o_timeout
);

  typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;

  state_t state;

  assign o_s_ready = (state == IDLE);
  assign o_busy    = (state != IDLE);

`ifdef HANDSHAKE_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] to_cnt;
  logic          aborted;   // current word was abandoned by the timeout
  logic          timeout_q;

  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

  // Handshake FSM: accept in IDLE, raise req, wait ack high, wait ack low.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      o_hs_valid   <= 1'b0;
      o_hs_data    <= '0;
      o_xfer_count <= '0;
`ifdef HANDSHAKE_TX_TIMEOUT_EN
      to_cnt       <= '0;
      aborted      <= 1'b0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // A stale ack here is ignored; REQ will simply see it immediately.
          if (i_s_valid) begin
            o_hs_data  <= i_s_data;
            o_hs_valid <= 1'b1;
            state      <= REQ;
`ifdef HANDSHAKE_TX_TIMEOUT_EN
            to_cnt     <= '0;
            aborted    <= 1'b0;
`endif
          end
        end
        REQ: begin
          if (i_hs_ack) begin
            o_hs_valid <= 1'b0;
            state      <= RELEASE;
          end
`ifdef HANDSHAKE_TX_TIMEOUT_EN
          // Counter holds the number of unacked REQ cycles already spent.
          else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            o_hs_valid <= 1'b0;
            timeout_q  <= 1'b1;
            aborted    <= 1'b1;
            state      <= RELEASE;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
`endif
        end
        RELEASE: begin
          // Data stays frozen until ack is seen low, closing the 4-phase loop.
          if (!i_hs_ack) begin
            state <= IDLE;
`ifdef HANDSHAKE_TX_TIMEOUT_EN
            if (!aborted)
`endif
              o_xfer_count <= o_xfer_count + COUNT_WIDTH'(1);
          end
        end
        default: begin
          state      <= IDLE;
          o_hs_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
